// File: rtl/ctrl_fsm_mc.sv
// Multicycle control unit for the 16-bit CPU: sequences fetch / decode / data
// access over a req/ack memory port, evaluates branches, traps faults, counts retires.
module ctrl_fsm_mc #(
    parameter int OPW          = 5,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 16,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic             flag_n,
    input  logic             flag_z,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_load,
    output logic             ALUOp,
    output logic             ALUSrc,
    output logic             ExtSel,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [2:0]       WBSrc,
    output logic             NZ,
    output logic             BrSrc,
    output logic             pc_enable,
    output logic             pc_inc,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] instr_count
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [4:0] OP_MV    = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_CMP   = 5'b00011;
    localparam logic [4:0] OP_LD    = 5'b00100;
    localparam logic [4:0] OP_ST    = 5'b00101;
    localparam logic [4:0] OP_JR    = 5'b01000;
    localparam logic [4:0] OP_JZR   = 5'b01001;
    localparam logic [4:0] OP_JNR   = 5'b01010;
    localparam logic [4:0] OP_CALLR = 5'b01100;
    localparam logic [4:0] OP_MVI   = 5'b10000;
    localparam logic [4:0] OP_ADDI  = 5'b10001;
    localparam logic [4:0] OP_SUBI  = 5'b10010;
    localparam logic [4:0] OP_CMPI  = 5'b10011;
    localparam logic [4:0] OP_MVHI  = 5'b10110;
    localparam logic [4:0] OP_J     = 5'b11000;
    localparam logic [4:0] OP_JZ    = 5'b11001;
    localparam logic [4:0] OP_JN    = 5'b11010;
    localparam logic [4:0] OP_CALL  = 5'b11100;

    localparam logic [2:0] WB_MEM  = 3'b000;
    localparam logic [2:0] WB_ALU  = 3'b001;
    localparam logic [2:0] WB_PC2  = 3'b010;
    localparam logic [2:0] WB_RY   = 3'b011;
    localparam logic [2:0] WB_IMM8 = 3'b100;
    localparam logic [2:0] WB_HI   = 3'b101;

    localparam logic [1:0] TC_FETCH   = 2'b01;
    localparam logic [1:0] TC_DATA    = 2'b10;
    localparam logic [1:0] TC_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_TRAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          st_pending;
    logic          expired;
    logic          br_taken;
    logic          dec_retire;
    logic          retire;
    logic          trap_set;
    logic [1:0]    trap_code_nxt;
    logic [4:0]    op5;

    assign op5     = opcode[4:0];
    assign expired = (wait_cnt == WAIT_LAST);

    // Condition select from the low opcode bits; flags are sampled in DECODE.
    always_comb begin
        br_taken = 1'b0;
        case (op5[1:0])
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = flag_z;
            2'b10:   br_taken = flag_n;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel       = 1'b0;
        ir_load       = 1'b0;
        ALUOp         = 1'b0;
        ALUSrc        = 1'b0;
        ExtSel        = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        WBSrc         = WB_MEM;
        NZ            = 1'b0;
        BrSrc         = 1'b0;
        pc_enable     = 1'b0;
        pc_inc        = 1'b0;
        busy          = 1'b0;
        dec_retire    = 1'b0;
        retire        = 1'b0;
        trap_set      = 1'b0;
        trap_code_nxt = 2'b00;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (expired) begin
                    trap_set      = 1'b1;
                    trap_code_nxt = TC_FETCH;
                    state_nxt     = S_TRAP;
                end
            end

            S_DECODE: begin
                case (op5)
                    OP_MV: begin
                        RegWrite = 1'b1; WBSrc = WB_RY; dec_retire = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        RegWrite = 1'b1; ALUOp = op5[1]; WBSrc = WB_ALU; dec_retire = 1'b1;
                    end
                    OP_CMP: begin
                        ALUOp = 1'b1; NZ = 1'b1; dec_retire = 1'b1;
                    end
                    OP_MVI: begin
                        RegWrite = 1'b1; WBSrc = WB_IMM8; dec_retire = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        RegWrite = 1'b1; ALUSrc = 1'b1; ALUOp = op5[1]; NZ = 1'b1;
                        WBSrc = WB_ALU; dec_retire = 1'b1;
                    end
                    OP_CMPI: begin
                        ALUSrc = 1'b1; ALUOp = 1'b1; NZ = 1'b1; WBSrc = WB_ALU;
                        dec_retire = 1'b1;
                    end
                    OP_MVHI: begin
                        RegWrite = 1'b1; WBSrc = WB_HI; dec_retire = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        state_nxt = S_MEM;
                    end
                    OP_JR, OP_JZR, OP_JNR, OP_J, OP_JZ, OP_JN, OP_CALLR, OP_CALL: begin
                        BrSrc      = op5[4];
                        ExtSel     = 1'b1;
                        pc_enable  = br_taken;
                        dec_retire = 1'b1;
                        // Link register is written whether or not the call is taken.
                        if (op5 == OP_CALLR || op5 == OP_CALL) begin
                            RegWrite = 1'b1;
                            RegDst   = 1'b1;
                            WBSrc    = WB_PC2;
                        end
                    end
                    default: begin
                        if (ILLEGAL_TRAP != 0) begin
                            trap_set      = 1'b1;
                            trap_code_nxt = TC_ILLEGAL;
                            state_nxt     = S_TRAP;
                        end else begin
                            dec_retire = 1'b1;
                        end
                    end
                endcase
                if (dec_retire) begin
                    retire    = 1'b1;
                    pc_inc    = ~pc_enable;
                    state_nxt = S_FETCH;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = st_pending;
                busy    = 1'b1;
                if (mem_ack) begin
                    RegWrite  = ~st_pending;
                    WBSrc     = WB_MEM;
                    pc_inc    = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (expired) begin
                    trap_set      = 1'b1;
                    trap_code_nxt = TC_DATA;
                    state_nxt     = S_TRAP;
                end
            end

            S_TRAP: begin
                state_nxt = S_TRAP;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            st_pending  <= 1'b0;
            trap        <= 1'b0;
            trap_code   <= 2'b00;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            // Counter restarts on every state entry and saturates at the expiry value.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !expired)
                wait_cnt <= wait_cnt + CW'(1);
            if (state == S_DECODE)
                st_pending <= (op5 == OP_ST);
            if (trap_set) begin
                trap      <= 1'b1;
                trap_code <= trap_code_nxt;
            end
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Randomized scoreboard bench for ctrl_fsm_mc: a transaction-level model pushes the
// expected per-cycle outputs; a monitor pops and compares them at each falling edge.
module tb_ctrl_fsm_mc;

    localparam int TO = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic       mem_req, mem_we, mem_sel, ir_load;
        logic       alu_op, alu_src, ext_sel, reg_write, reg_dst;
        logic [2:0] wb_src;
        logic       nz, br_src, pc_enable, pc_inc, busy, trap;
        logic [1:0] trap_code;
        logic [3:0] cnt;
    } outs_t;

    typedef struct {
        outs_t a;
        outs_t b;
        string tag;
    } exp_t;

    logic       clk, reset_n, rst_b_n, start, flag_n, flag_z, mem_ack;
    logic [4:0] opcode;

    logic a_mem_req, a_mem_we, a_mem_sel, a_ir_load, a_alu_op, a_alu_src, a_ext_sel;
    logic a_reg_write, a_reg_dst, a_nz, a_br_src, a_pc_enable, a_pc_inc, a_busy, a_trap;
    logic [2:0] a_wb_src;
    logic [1:0] a_trap_code;
    logic [3:0] a_cnt;
    logic b_mem_req, b_mem_we, b_mem_sel, b_ir_load, b_alu_op, b_alu_src, b_ext_sel;
    logic b_reg_write, b_reg_dst, b_nz, b_br_src, b_pc_enable, b_pc_inc, b_busy, b_trap;
    logic [2:0] b_wb_src;
    logic [1:0] b_trap_code;
    logic [3:0] b_cnt;

    outs_t act_a, act_b;
    assign act_a = {a_mem_req, a_mem_we, a_mem_sel, a_ir_load, a_alu_op, a_alu_src, a_ext_sel,
                    a_reg_write, a_reg_dst, a_wb_src, a_nz, a_br_src, a_pc_enable, a_pc_inc,
                    a_busy, a_trap, a_trap_code, a_cnt};
    assign act_b = {b_mem_req, b_mem_we, b_mem_sel, b_ir_load, b_alu_op, b_alu_src, b_ext_sel,
                    b_reg_write, b_reg_dst, b_wb_src, b_nz, b_br_src, b_pc_enable, b_pc_inc,
                    b_busy, b_trap, b_trap_code, b_cnt};

    // Main unit retires illegal opcodes as nops; second unit traps on them.
    ctrl_fsm_mc #(.OPW(5), .TIMEOUT(TO), .CNT_W(CW), .ILLEGAL_TRAP(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
        .flag_n(flag_n), .flag_z(flag_z), .mem_ack(mem_ack),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_sel(a_mem_sel), .ir_load(a_ir_load),
        .ALUOp(a_alu_op), .ALUSrc(a_alu_src), .ExtSel(a_ext_sel), .RegWrite(a_reg_write),
        .RegDst(a_reg_dst), .WBSrc(a_wb_src), .NZ(a_nz), .BrSrc(a_br_src),
        .pc_enable(a_pc_enable), .pc_inc(a_pc_inc), .busy(a_busy), .trap(a_trap),
        .trap_code(a_trap_code), .instr_count(a_cnt));

    ctrl_fsm_mc #(.OPW(5), .TIMEOUT(TO), .CNT_W(CW), .ILLEGAL_TRAP(1)) dut_t (
        .clk(clk), .reset_n(rst_b_n), .start(start), .opcode(opcode),
        .flag_n(flag_n), .flag_z(flag_z), .mem_ack(mem_ack),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_sel(b_mem_sel), .ir_load(b_ir_load),
        .ALUOp(b_alu_op), .ALUSrc(b_alu_src), .ExtSel(b_ext_sel), .RegWrite(b_reg_write),
        .RegDst(b_reg_dst), .WBSrc(b_wb_src), .NZ(b_nz), .BrSrc(b_br_src),
        .pc_enable(b_pc_enable), .pc_inc(b_pc_inc), .busy(b_busy), .trap(b_trap),
        .trap_code(b_trap_code), .instr_count(b_cnt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    int       cnt_a, cnt_b;
    bit       trap_a, trap_b, b_live;
    bit [1:0] code_a, code_b;

    logic [4:0] legal_ops [0:18] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b10000,
        5'b10001, 5'b10010, 5'b10011, 5'b10110, 5'b00100, 5'b00101, 5'b01000, 5'b01001,
        5'b01010, 5'b11000, 5'b11001, 5'b11010, 5'b01100, 5'b11100};

    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (act_a !== mon_e.a) begin
                errors++;
                $display("FAIL %s (unit nop-illegal): got %h want %h", mon_e.tag, act_a, mon_e.a);
            end
            checks++;
            if (act_b !== mon_e.b) begin
                errors++;
                $display("FAIL %s (unit trap-illegal): got %h want %h", mon_e.tag, act_b, mon_e.b);
            end
        end
    end

    function automatic outs_t base_a();
        outs_t o = '0;
        o.trap = trap_a; o.trap_code = code_a; o.cnt = 4'(cnt_a);
        return o;
    endfunction

    function automatic outs_t base_b();
        outs_t o = '0;
        o.trap = trap_b; o.trap_code = code_b; o.cnt = 4'(cnt_b);
        return o;
    endfunction

    task automatic push2(input outs_t sa, input outs_t sb, input string tag);
        exp_t e;
        e.a = sa | base_a();
        e.b = b_live ? (sb | base_b()) : outs_t'('0);
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic push_cyc(input outs_t s, input string tag);
        push2(s, s, tag);
    endtask

    // Reference decode: strobes for one DECODE cycle from the instruction-set table.
    function automatic void dec(input logic [4:0] op, input bit fz, input bit fn,
                                output outs_t s, output bit ret, output bit to_mem,
                                output bit illegal);
        bit taken;
        s = '0; ret = 1; to_mem = 0; illegal = 0; taken = 0;
        case (op)
            5'b00000: begin s.reg_write = 1; s.wb_src = 3'b011; end
            5'b00001: begin s.reg_write = 1; s.wb_src = 3'b001; end
            5'b00010: begin s.reg_write = 1; s.wb_src = 3'b001; s.alu_op = 1; end
            5'b00011: begin s.alu_op = 1; s.nz = 1; end
            5'b10000: begin s.reg_write = 1; s.wb_src = 3'b100; end
            5'b10001: begin s.reg_write = 1; s.alu_src = 1; s.nz = 1; s.wb_src = 3'b001; end
            5'b10010: begin s.reg_write = 1; s.alu_src = 1; s.nz = 1; s.wb_src = 3'b001; s.alu_op = 1; end
            5'b10011: begin s.alu_src = 1; s.nz = 1; s.wb_src = 3'b001; s.alu_op = 1; end
            5'b10110: begin s.reg_write = 1; s.wb_src = 3'b101; end
            5'b00100, 5'b00101: begin ret = 0; to_mem = 1; end
            5'b01000, 5'b01001, 5'b01010, 5'b11000, 5'b11001, 5'b11010, 5'b01100, 5'b11100: begin
                if (op[1:0] == 2'b00) taken = 1;
                else if (op[1:0] == 2'b01) taken = fz;
                else taken = fn;
                s.ext_sel = 1; s.br_src = op[4]; s.pc_enable = taken;
                if (op == 5'b01100 || op == 5'b11100) begin
                    s.reg_write = 1; s.reg_dst = 1; s.wb_src = 3'b010;
                end
            end
            default: illegal = 1;
        endcase
        if (ret && !s.pc_enable) s.pc_inc = 1;
    endfunction

    task automatic do_reset();
        reset_n = 0; rst_b_n = 0; start = 0; mem_ack = 0;
        cnt_a = 0; cnt_b = 0; trap_a = 0; trap_b = 0; code_a = 0; code_b = 0;
        push_cyc('0, "reset");
        mem_ack = 1;
        push_cyc('0, "reset");
        reset_n = 1;
        if (b_live) rst_b_n = 1;
    endtask

    task automatic go();
        start = 0; mem_ack = 1'($urandom); opcode = 5'($urandom);
        push_cyc('0, "idle");
        start = 1;
        push_cyc('0, "idle_start");
        start = 0;
    endtask

    task automatic fetch(input int waits, output bit ok);
        outs_t s;
        ok = 0;
        for (int k = 0; k < TO; k++) begin
            s = '0;
            mem_ack = (k == waits);
            opcode = 5'($urandom);
            s.mem_req = 1; s.ir_load = mem_ack;
            push_cyc(s, "fetch");
            if (k == waits) begin ok = 1; break; end
        end
        if (!ok) begin
            trap_a = 1; code_a = 2'b01;
            if (b_live) begin trap_b = 1; code_b = 2'b01; end
        end
    endtask

    task automatic decode(input logic [4:0] op, input bit fz, input bit fn, output bit to_mem);
        outs_t s;
        bit ret, ill;
        opcode = op; flag_z = fz; flag_n = fn; mem_ack = 1'($urandom);
        dec(op, fz, fn, s, ret, to_mem, ill);
        if (b_live && ill) begin
            push2(s, '0, "decode_illegal");
            trap_b = 1; code_b = 2'b11;
        end else begin
            push_cyc(s, "decode");
            if (b_live && ret) cnt_b = (cnt_b + 1) % 16;
        end
        if (ret) cnt_a = (cnt_a + 1) % 16;
    endtask

    task automatic memacc(input bit st, input int waits);
        outs_t s;
        bit ok = 0;
        for (int k = 0; k < TO; k++) begin
            s = '0;
            mem_ack = (k == waits);
            opcode = 5'($urandom);
            s.mem_req = 1; s.mem_sel = 1; s.mem_we = st; s.busy = 1;
            if (mem_ack) begin s.pc_inc = 1; s.reg_write = !st; end
            push_cyc(s, st ? "mem_st" : "mem_ld");
            if (k == waits) begin ok = 1; cnt_a = (cnt_a + 1) % 16; break; end
        end
        if (!ok) begin trap_a = 1; code_a = 2'b10; end
    endtask

    task automatic instr(input logic [4:0] op, input int fw, input int dw, input bit fz, input bit fn);
        bit ok, to_mem;
        fetch(fw, ok);
        if (!ok) return;
        decode(op, fz, fn, to_mem);
        if (to_mem) memacc(op == 5'b00101, dw);
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1; mem_ack = 1'($urandom); opcode = 5'($urandom);
            push_cyc('0, "trap_hold");
        end
        start = 0;
    endtask

    initial begin
        bit ok, to_mem;
        outs_t s;
        logic [4:0] op;
        reset_n = 0; rst_b_n = 0; start = 0; mem_ack = 0; opcode = 0;
        flag_n = 0; flag_z = 0; b_live = 0;
        @(posedge clk);
        #1;

        do_reset();
        go();
        instr(5'b00001, 3, 0, 0, 0);   // add, ack on the expiry cycle
        instr(5'b00100, 0, 2, 0, 0);   // ld, two data waits
        instr(5'b00101, 1, 1, 0, 0);   // st
        instr(5'b11001, 0, 0, 1, 0);   // jz taken
        instr(5'b11001, 0, 0, 0, 1);   // jz not taken
        instr(5'b01100, 0, 0, 0, 0);   // callr
        instr(5'b11100, 1, 0, 0, 0);   // call
        instr(5'b01010, 0, 0, 0, 0);   // jnr not taken
        instr(5'b11111, 0, 0, 1, 1);   // illegal retires as nop

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else op = legal_ops[$urandom_range(0, 18)];
            instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        // Reset while a data access is outstanding.
        fetch(0, ok);
        decode(5'b00100, 0, 0, to_mem);
        s = '0; s.mem_req = 1; s.mem_sel = 1; s.busy = 1; mem_ack = 0;
        push_cyc(s, "mem_ld");
        do_reset();

        // Data timeout, then trap must hold against start and mem_ack.
        go();
        fetch(0, ok);
        decode(5'b00101, 0, 0, to_mem);
        memacc(1, 99);
        trap_hold(3);

        // Fetch timeout.
        do_reset();
        go();
        fetch(99, ok);
        trap_hold(2);

        // Both units in lockstep up to an illegal opcode.
        b_live = 1;
        do_reset();
        go();
        fetch(1, ok);
        decode(5'b11111, 0, 0, to_mem);
        for (int k = 0; k < 3; k++) begin
            s = '0; s.mem_req = 1;
            mem_ack = 0; start = 1;
            push2(s, '0, "after_illegal");
        end
        start = 0;

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
